// File: rtl/axi_aw_w_aligner_if.sv
// Upstream/downstream AXI write-address and write-data channel bundle.
// The master side drives valid and payload; the slave side drives ready.
interface axi_aw_w_aligner_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [1:0]              awburst;
    logic [2:0]              awsize;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    modport master (
        output awaddr, awid, awburst, awsize, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready
    );

    modport slave (
        input  awaddr, awid, awburst, awsize, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready
    );
endinterface

// File: rtl/axi_aw_w_aligner.sv
// Buffers AXI AW and W channels independently, then re-issues each AW
// followed by exactly AWLEN+1 W beats. Downstream WLAST is regenerated
// from AWLEN; a disagreeing upstream WLAST raises the sticky err_wlast.
module axi_aw_w_aligner #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 4,
    parameter int AW_DEPTH      = 4,
    parameter int W_DEPTH       = 16,
    parameter int WAIT_FOR_DATA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_aw_w_aligner_if.slave  up_if,
    axi_aw_w_aligner_if.master dn_if,
    output logic               err_wlast,
    output logic               busy
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AP         = $clog2(AW_DEPTH);
    localparam int WP         = $clog2(W_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            burst;
        logic [2:0]            size;
        logic [7:0]            len;
    } aw_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } w_t;

    typedef enum logic {ST_ADDR, ST_DATA} state_e;

    aw_t         aw_mem [AW_DEPTH];
    w_t          w_mem  [W_DEPTH];
    logic [AP:0] aw_wr_q, aw_wr_d, aw_rd_q, aw_rd_d;
    logic [WP:0] w_wr_q, w_wr_d, w_rd_q, w_rd_d;
    aw_t         aw_in, aw_head;
    w_t          w_in, w_head;
    logic        aw_empty, aw_full, w_empty, w_full;
    logic        aw_push, aw_pop, w_push, w_pop;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
    assign aw_empty = (aw_wr_q == aw_rd_q);
    assign aw_full  = (aw_wr_q[AP] != aw_rd_q[AP]) && (aw_wr_q[AP-1:0] == aw_rd_q[AP-1:0]);
    assign w_empty  = (w_wr_q == w_rd_q);
    assign w_full   = (w_wr_q[WP] != w_rd_q[WP]) && (w_wr_q[WP-1:0] == w_rd_q[WP-1:0]);

    // Readiness depends only on fullness, so a full FIFO refuses a push even while popping.
    assign up_if.awready = rst_n && !aw_full;
    assign up_if.wready  = rst_n && !w_full;
    assign aw_push       = up_if.awvalid && up_if.awready;
    assign w_push        = up_if.wvalid && up_if.wready;
    assign aw_pop        = dn_if.awvalid && dn_if.awready;
    assign w_pop         = dn_if.wvalid && dn_if.wready;

    assign aw_in   = {up_if.awaddr, up_if.awid, up_if.awburst, up_if.awsize, up_if.awlen};
    assign w_in    = {up_if.wdata, up_if.wstrb, up_if.wlast};
    assign aw_head = aw_mem[aw_rd_q[AP-1:0]];
    assign w_head  = w_mem[w_rd_q[WP-1:0]];

    assign err_wlast = err_q;
    assign busy      = rst_n && ((state_q == ST_DATA) || !aw_empty || !w_empty);

    // Next pointer values: advance by one on each accepted push or pop.
    always_comb begin
        aw_wr_d = aw_wr_q + (AP+1)'(aw_push);
        aw_rd_d = aw_rd_q + (AP+1)'(aw_pop);
        w_wr_d  = w_wr_q + (WP+1)'(w_push);
        w_rd_d  = w_rd_q + (WP+1)'(w_pop);
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            aw_wr_q <= '0;
            aw_rd_q <= '0;
            w_wr_q  <= '0;
            w_rd_q  <= '0;
        end else begin
            aw_wr_q <= aw_wr_d;
            aw_rd_q <= aw_rd_d;
            w_wr_q  <= w_wr_d;
            w_rd_q  <= w_rd_d;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; clearing the pointers is enough to discard its contents.
        if (aw_push) aw_mem[aw_wr_q[AP-1:0]] <= aw_in;
        if (w_push)  w_mem[w_wr_q[WP-1:0]]   <= w_in;
    end

    // State register: FSM state, remaining-beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: issue one AW, then count AWLEN+1 W handshakes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_ADDR: begin
                if (aw_pop) begin
                    state_d = ST_DATA;
                    cnt_d   = aw_head.len;
                end
            end
            ST_DATA: begin
                if (w_pop) begin
                    if (w_head.last != (cnt_q == 8'd0)) err_d = 1'b1;
                    if (cnt_q == 8'd0) state_d = ST_ADDR;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output logic: present FIFO heads downstream, payload forced to zero while not valid.
    always_comb begin
        dn_if.awvalid = 1'b0;
        dn_if.awaddr  = '0;
        dn_if.awid    = '0;
        dn_if.awburst = '0;
        dn_if.awsize  = '0;
        dn_if.awlen   = '0;
        dn_if.wvalid  = 1'b0;
        dn_if.wdata   = '0;
        dn_if.wstrb   = '0;
        dn_if.wlast   = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (rst_n && !aw_empty && (WAIT_FOR_DATA == 0 || !w_empty)) begin
                    dn_if.awvalid = 1'b1;
                    {dn_if.awaddr, dn_if.awid, dn_if.awburst, dn_if.awsize, dn_if.awlen} = aw_head;
                end
            end
            ST_DATA: begin
                if (rst_n && !w_empty) begin
                    dn_if.wvalid = 1'b1;
                    dn_if.wdata  = w_head.data;
                    dn_if.wstrb  = w_head.strb;
                    dn_if.wlast  = (cnt_q == 8'd0);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/axi_aw_w_aligner.md
AXI_AW_W_ALIGNER -- requirements
Module: axi_aw_w_aligner

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter DATA_WIDTH, default 64, W data width; strobe width is DATA_WIDTH/8.
REQ-003 Parameter ID_WIDTH, default 4, AWID width.
REQ-004 Parameter AW_DEPTH, default 4, AW FIFO entries; power of 2, >=2.
REQ-005 Parameter W_DEPTH, default 16, W FIFO entries; power of 2, >=2.
REQ-006 Parameter WAIT_FOR_DATA, default 1; 1 = AW issued only once at least one W beat is buffered.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 in_awaddr/in_awid/in_awburst/in_awsize/in_awlen  input  ADDR_WIDTH/ID_WIDTH/2/3/8  upstream AW payload.
REQ-010 in_awvalid input 1, in_awready output 1  upstream AW handshake.
REQ-011 in_wdata/in_wstrb/in_wlast  input  DATA_WIDTH/DATA_WIDTH/8/1  upstream W payload.
REQ-012 in_wvalid input 1, in_wready output 1  upstream W handshake.
REQ-013 out_awaddr/out_awid/out_awburst/out_awsize/out_awlen  output  same widths  downstream AW payload.
REQ-014 out_awvalid output 1, out_awready input 1  downstream AW handshake.
REQ-015 out_wdata/out_wstrb/out_wlast  output  DATA_WIDTH/DATA_WIDTH/8/1  downstream W payload.
REQ-016 out_wvalid output 1, out_wready input 1  downstream W handshake.
REQ-017 err_wlast  output  1  sticky: upstream WLAST disagreed with AWLEN-derived beat count.
REQ-018 busy  output  1  high while any AW/W is buffered or a burst is in progress.

Function
REQ-019 AW FIFO: in_awready = !aw_full; push on in_awvalid && in_awready; stores addr, id, burst, size, len.
REQ-020 W FIFO: in_wready = !w_full; push on in_wvalid && in_wready; stores data, strb, last.
REQ-021 Ready depends on full only; a full FIFO refuses a push even when the same cycle pops it.
REQ-022 FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty come from the MSB/LSB comparison.
REQ-023 Output FSM states: ADDR and DATA.
REQ-024 ADDR: out_awvalid = !aw_empty && (WAIT_FOR_DATA==0 || !w_empty); out_aw* = AW FIFO head; out_wvalid = 0.
REQ-025 ADDR -> DATA on out_awvalid && out_awready: pop AW; load 8-bit beat counter with head awlen.
REQ-026 DATA: out_wvalid = !w_empty; out_wdata/out_wstrb = W FIFO head; out_wlast = (beat counter == 0); out_awvalid = 0.
REQ-027 DATA, on out_wvalid && out_wready: pop W; if counter == 0, go to ADDR, else decrement.
REQ-028 Each DATA handshake with stored last != out_wlast sets err_wlast; only reset clears it.
REQ-029 Downstream WLAST comes from AWLEN, never from upstream wlast.
REQ-030 Valid, once asserted, is held with stable payload until handshake; payload outputs are 0 while their valid is low.
REQ-031 Latency: both FIFOs empty, AW and W accepted cycle 0 -> out_awvalid cycle 1; with out_awready high then, out_wvalid cycle 2.
REQ-032 Upstream pushes are independent of FSM state; W for later bursts may buffer during an earlier burst.
REQ-033 busy = (state==DATA) || !aw_empty || !w_empty.

Reset
REQ-034 rst_n low at a rising edge clears FIFO pointers, state to ADDR, beat counter to 0, err_wlast to 0, even mid-burst.
REQ-035 While rst_n is low: in_awready=0, in_wready=0, out_awvalid=0, out_wvalid=0, busy=0, all payload outputs 0; readies rise the first cycle after release.
REQ-036 FIFO storage is not reset; buffered transactions are discarded.

Verification
REQ-037 Single beat: AW len=0 addr=0x1000 id=3 plus one W 0xA5.., downstream always ready -> AW cycle 1, W wlast=1 cycle 2, err_wlast=0.
REQ-038 Burst len=7, out_wready toggling -> 8 beats in order, wlast only on 8th, FSM back in ADDR, busy low after.
REQ-039 W arrives 5 cycles after AW, WAIT_FOR_DATA=1 -> out_awvalid low until first beat buffered; WAIT_FOR_DATA=0 -> out_awvalid cycle 1.
REQ-040 Downstream stalled, push AW_DEPTH AWs and W_DEPTH beats -> in_awready/in_wready low when full; no loss or reorder after release; pointers wrap correctly.
REQ-041 AW len=3, upstream wlast on beat 2 -> 4 beats out, wlast on beat 4, err_wlast high from handshake of beat 2.
REQ-042 rst_n low during beat 3 of a len=7 burst -> all valids 0, busy 0, err_wlast 0; a fresh transaction after release completes normally.
